// File: rtl/pwm_generator.sv
// PWM generator: double-buffered WIDTH-bit duty, new values applied only at period boundaries.
// Outputs are registered alongside the phase counter; duty_load is always accepted, no backpressure.
module pwm_generator #(
  parameter int PRESCALE = 1,
  parameter int WIDTH    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty,
  input  logic             duty_load,
  output logic             pwm,
  output logic             period_start,
  output logic [WIDTH-1:0] duty_active
);

  localparam int               PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST   = PW'(PRESCALE - 1);
  // Phase stops one short of all-ones so duty 0 is fully off and all-ones is fully on.
  localparam logic [WIDTH-1:0] PHASE_LAST = WIDTH'((2 ** WIDTH) - 2);

  logic [PW-1:0]    pre_cnt;
  logic [WIDTH-1:0] phase;
  logic [WIDTH-1:0] pending;
  logic             pending_valid;
  logic             tick;
  logic             wrap;
  logic [WIDTH-1:0] phase_next;
  logic [WIDTH-1:0] duty_active_next;

  assign tick = enable && (pre_cnt == PRE_LAST);
  assign wrap = tick && (phase == PHASE_LAST);

  always_comb begin
    phase_next = phase;
    if (wrap) begin
      phase_next = '0;
    end else if (tick) begin
      phase_next = phase + 1'b1;
    end
  end

  // A load landing on the wrap cycle is newer than anything already pending.
  always_comb begin
    duty_active_next = duty_active;
    if (wrap) begin
      if (duty_load) begin
        duty_active_next = duty;
      end else if (pending_valid) begin
        duty_active_next = pending;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (enable) begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase       <= '0;
      duty_active <= '0;
    end else begin
      phase       <= phase_next;
      duty_active <= duty_active_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending       <= '0;
      pending_valid <= 1'b0;
    end else begin
      if (duty_load) begin
        pending <= duty;
      end
      if (wrap) begin
        pending_valid <= 1'b0;
      end else if (duty_load) begin
        pending_valid <= 1'b1;
      end
    end
  end

  // Compare against the values being registered this edge so pwm lines up with phase.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pwm          <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pwm          <= enable && (phase_next < duty_active_next);
      period_start <= wrap;
    end
  end

endmodule

// File: doc/pwm_generator.md
# pwm_generator

Converts an 8-bit duty value into a single-bit pulse-width-modulated output. It is the consumer side of the duty-value interface: a source such as the triangle up/down counter, or a register, drives `duty`, and this block produces the `pwm` pin drive, for example for an LED. New duty values are double-buffered and take effect only at period boundaries, so the output never glitches mid-period.

## Interface

- `PRESCALE`, default 1: clock cycles per PWM tick. Legal values are 1 and up.
- `WIDTH`, default 8: duty and phase width in bits.
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `enable`  in  1: run control. While low, the counters hold and `pwm` is forced low.
- `duty`  in  WIDTH: requested duty value.
- `duty_load`  in  1: single-cycle strobe that captures `duty` into the pending register.
- `pwm`  out  1: registered PWM output.
- `period_start`  out  1: one-cycle pulse marking the start of each period.
- `duty_active`  out  WIDTH: duty value currently being applied.

## Operation

- **Prescaler `pre_cnt`.**
  - Counts 0..PRESCALE-1 while `enable`=1, then wraps.
  - `tick` = `enable` && `pre_cnt`==PRESCALE-1.
  - With PRESCALE=1, `tick` = `enable`.
- **Phase counter `phase`.**
  - WIDTH bits wide; advances on `tick` through 0..2^WIDTH-2, then wraps to 0.
  - Period is 2^WIDTH-1 ticks (255 for WIDTH=8).
  - The value 2^WIDTH-1 is never reached. This makes duty 0 fully off and duty 2^WIDTH-1 fully on.
- **Boundary.** `wrap` = `tick` && `phase`==2^WIDTH-2.
- **Shadow register.**
  - `duty_load`=1 writes `duty` into `pending` and sets `pending_valid`.
  - On `wrap`, if `pending_valid` (or `duty_load` in the same cycle) is set:
    - `duty_active` takes the newest value. A same-cycle `duty_load` wins over the older `pending`.
    - `pending_valid` clears.
  - On `wrap` with nothing pending, `duty_active` is unchanged.
  - Multiple loads within one period: only the last one is applied. Intermediate values never appear on `duty_active`.
- **Compare.**
  - `pwm` is registered: `pwm` <= `enable` && (`phase_next` < `duty_active_next`).
  - `phase_next` and `duty_active_next` are the values being registered on the same edge, so `pwm` is aligned with the registered `phase`.
  - Compare is unsigned, WIDTH bits.
- **Period marker.** `period_start` <= `wrap`. It is high for exactly the one cycle in which `phase`=0 and the new `duty_active` are first visible.
- **Enable low.**
  - `pre_cnt`, `phase`, `duty_active` and `pending_valid` hold.
  - `duty_load` is still accepted.
  - `pwm` goes low at the next edge.
  - On re-enable, counting resumes from the held state. The current period is stretched by the disabled time.
- **Reset.**
  - Asserting `reset` immediately forces, without a clock edge: `pre_cnt`=0, `phase`=0, `pending`=0, `pending_valid`=0, `duty_active`=0, `pwm`=0, `period_start`=0.
  - Any pending load is discarded.
  - Counting starts on the first edge after `reset` deasserts (if `enable`=1).

## Timing

- **Period:** (2^WIDTH-1)·PRESCALE clocks with `enable` continuously high; 255 clocks at the defaults.
- **High time:** `duty_active`·PRESCALE clocks per period, contiguous, starting in the `period_start` cycle.
- **Load-to-effect latency:** from 1 clock (load coincident with `wrap`) up to one full period. There is never a partial-period change.
- **Output registration:** `pwm` and `period_start` are registered outputs, updated on the same edge as `phase`.
- **First period after reset:** `duty_active`=0, so `pwm` stays low for the whole first period regardless of loads.

## Test plan

1. **Basic duty:** PRESCALE=1, reset, then `duty_load` with `duty`=128 at cycle 3 after reset.
   - `pwm` is low for the first 255 cycles.
   - `period_start` pulses, then `pwm` is high for 128 cycles and low for 127, repeating.
   - `duty_active`=128 from the `period_start` cycle onward.
2. **Extremes:**
   - With `duty`=0: `pwm` is never high across 3 periods.
   - With `duty`=255: `pwm` stays high continuously across 3 boundaries with no low cycle.
   - `period_start` still pulses every 255 cycles in both cases.
3. **Multiple loads in one period:** load 50 at phase 10, then 200 at phase 100.
   - At the next boundary `duty_active` becomes 200; it never shows 50.
   - `pwm` is then high for 200 cycles.
4. **Load coincident with wrap:** `duty_load` with `duty`=30 in the `wrap` cycle, while 90 is already pending.
   - `duty_active`=30 in the `period_start` cycle.
   - `pwm` is high for 30 cycles.
5. **Prescale and enable:** PRESCALE=4, `duty`=10 active.
   - `pwm` is high for 40 clocks per 1020-clock period.
   - Drop `enable` for 12 clocks at phase 5: `pwm` is low during the gap, `phase` holds at 5, and that period measures 1032 clocks.
6. **Reset mid-operation:** assert `reset` while `pwm`=1, between clock edges.
   - `pwm`, `duty_active` and `period_start` read 0 before the next edge.
   - After release, the first period is fully low and the previously pending value is not applied.
